// File: rtl/weight_pingpong_buffer.sv
// Double-banked weight store: the loader fills one bank while the PE array
// drains the other, and each filled bank is replayed a programmable number of
// passes before it is handed back to the writer.
module weight_pingpong_buffer #(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8,
    parameter int unsigned RPT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [N-1:0]     wr_data,
    output logic             wr_ready,
    input  logic             flush,
    input  logic [RPT_W-1:0] pass_count,
    output logic             rd_valid,
    output logic [N-1:0]     rd_data,
    output logic             rd_last,
    output logic             rd_final,
    input  logic             rd_ready,
    output logic             wr_bank,
    output logic             rd_bank,
    output logic [1:0]       bank_full
);

    typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_st_e;

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    logic [N-1:0]     mem_q [2][DEPTH];
    bank_st_e         state_q [2];
    bank_st_e         state_d [2];
    logic [RPT_W-1:0] pass_q [2];
    logic [RPT_W-1:0] pass_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [RPT_W-1:0] rd_pass_q, rd_pass_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_last_q, rd_last_d;
    logic             rd_final_q, rd_final_d;
    logic [N-1:0]     rd_data_q, rd_data_d;

    logic             wr_fire;
    logic             wr_wrap;
    logic             rd_load;
    logic             rd_wrap;
    logic [RPT_W-1:0] pass_max;
    logic             rd_final_pass;

    assign wr_ready = ((state_q[wr_bank_q] == StEmpty) || (state_q[wr_bank_q] == StFilling))
                      && !flush;
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_wrap  = (wr_addr_q == LastAddr);

    assign rd_load  = (!rd_valid_q || rd_ready) &&
                      ((state_q[rd_bank_q] == StFull) || (state_q[rd_bank_q] == StDraining));
    assign rd_wrap  = (rd_addr_q == LastAddr);
    // A programmed pass count of 0 behaves as a single pass.
    assign pass_max = (pass_q[rd_bank_q] == '0) ? '0 : pass_q[rd_bank_q] - RPT_W'(1);
    assign rd_final_pass = (rd_pass_q == pass_max);

    // Next-state for both bank FSMs, counters and the output register.
    // Writer and reader only ever act on banks in disjoint states, so their
    // updates to state_d never collide.
    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        rd_pass_d  = rd_pass_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;
        rd_final_d = rd_final_q;

        if (flush) begin
            wr_addr_d = '0;
            if (state_q[wr_bank_q] == StFilling) begin
                state_d[wr_bank_q] = StEmpty;
            end
        end else if (wr_fire) begin
            if (wr_wrap) begin
                wr_addr_d          = '0;
                state_d[wr_bank_q] = StFull;
                pass_d[wr_bank_q]  = pass_count;
                wr_bank_d          = ~wr_bank_q;
            end else begin
                wr_addr_d          = wr_addr_q + AW'(1);
                state_d[wr_bank_q] = StFilling;
            end
        end

        if (rd_load) begin
            rd_valid_d         = 1'b1;
            rd_data_d          = mem_q[rd_bank_q][rd_addr_q];
            rd_last_d          = rd_wrap;
            rd_final_d         = rd_wrap && rd_final_pass;
            state_d[rd_bank_q] = StDraining;
            if (rd_wrap) begin
                rd_addr_d = '0;
                if (rd_final_pass) begin
                    state_d[rd_bank_q] = StEmpty;
                    rd_bank_d          = ~rd_bank_q;
                    rd_pass_d          = '0;
                end else begin
                    rd_pass_d = rd_pass_q + RPT_W'(1);
                end
            end else begin
                rd_addr_d = rd_addr_q + AW'(1);
            end
        end else if (rd_ready) begin
            rd_valid_d = 1'b0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= StEmpty;
            state_q[1] <= StEmpty;
            pass_q[0]  <= '0;
            pass_q[1]  <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            rd_pass_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            rd_final_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_q     <= pass_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            rd_pass_q  <= rd_pass_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            rd_final_q <= rd_final_d;
        end
    end

    // Bank storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_addr_q] <= wr_data;
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_last      = rd_last_q;
    assign rd_final     = rd_final_q;
    assign wr_bank      = wr_bank_q;
    assign rd_bank      = rd_bank_q;
    assign bank_full[0] = (state_q[0] == StFull) || (state_q[0] == StDraining);
    assign bank_full[1] = (state_q[1] == StFull) || (state_q[1] == StDraining);

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Bench for weight_pingpong_buffer: directed table, corner-case sequences and
// random traffic checked against a queue-based reference model.
module tb_weight_pingpong_buffer;

    localparam int N     = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int RPT_W = 4;

    logic             clk;
    logic             rst;
    logic             wr_valid;
    logic [N-1:0]     wr_data;
    logic             wr_ready;
    logic             flush;
    logic [RPT_W-1:0] pass_count;
    logic             rd_valid;
    logic [N-1:0]     rd_data;
    logic             rd_last;
    logic             rd_final;
    logic             rd_ready;
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       bank_full;

    weight_pingpong_buffer #(
        .N(N), .DEPTH(DEPTH), .AW(AW), .RPT_W(RPT_W)
    ) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .flush(flush), .pass_count(pass_count), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .rd_final(rd_final), .rd_ready(rd_ready), .wr_bank(wr_bank),
        .rd_bank(rd_bank), .bank_full(bank_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words of each completed bank are expanded into the
    // full expected read stream (passes x DEPTH) and queued in bank order.
    typedef struct {
        logic [N-1:0] d;
        bit           last;
        bit           fin;
        bit           bank;
    } ent_t;

    ent_t         pend[$];
    logic [N-1:0] fillq[$];
    ent_t         e;
    bit           m_valid = 0;
    logic [N-1:0] m_data  = '0;
    bit           m_last  = 0;
    bit           m_fin   = 0;
    logic [1:0]   m_held  = 2'b00;
    bit           m_wbank = 0;
    bit           m_rbank = 0;
    bit           m_wr_ok;
    bit           m_ld;
    int           np;
    bit           chk_en  = 0;

    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            fillq.delete();
            m_valid = 0; m_data = '0; m_last = 0; m_fin = 0;
            m_held = 2'b00; m_wbank = 0; m_rbank = 0;
        end else begin
            m_wr_ok = !flush && !m_held[m_wbank];
            m_ld    = (!m_valid || rd_ready) && (pend.size() > 0);
            if (m_ld) begin
                e       = pend.pop_front();
                m_data  = e.d;
                m_last  = e.last;
                m_fin   = e.fin;
                m_valid = 1;
                if (e.fin) begin
                    m_held[e.bank] = 1'b0;
                    m_rbank        = ~m_rbank;
                end
            end else if (rd_ready) begin
                m_valid = 0;
            end
            if (flush) begin
                fillq.delete();
            end else if (wr_valid && m_wr_ok) begin
                fillq.push_back(wr_data);
                if (fillq.size() == DEPTH) begin
                    np = (pass_count == 0) ? 1 : int'(pass_count);
                    for (int p = 0; p < np; p++) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            e.d    = fillq[i];
                            e.last = (i == DEPTH - 1);
                            e.fin  = (i == DEPTH - 1) && (p == np - 1);
                            e.bank = m_wbank;
                            pend.push_back(e);
                        end
                    end
                    m_held[m_wbank] = 1'b1;
                    m_wbank         = ~m_wbank;
                    fillq.delete();
                end
            end
        end
    end

    // Per-cycle comparison against the model, stall stability, and counters
    // of words accepted by the consumer.
    bit           prev_stall = 0;
    logic [N-1:0] prev_data;
    bit           prev_last, prev_fin;
    int           acc_words = 0, acc_last = 0, acc_final = 0;
    logic [N-1:0] acc_first = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_valid", rd_valid, m_valid);
            chk("rd_data", rd_data, m_data);
            if (m_valid) begin
                chk("rd_last", rd_last, m_last);
                chk("rd_final", rd_final, m_fin);
            end
            chk("wr_ready", wr_ready, !flush && !m_held[m_wbank]);
            chk("bank_full", bank_full, m_held);
            chk("wr_bank", wr_bank, m_wbank);
            chk("rd_bank", rd_bank, m_rbank);
            if (prev_stall) begin
                chk("stall_valid", rd_valid, 1'b1);
                chk("stall_data", rd_data, prev_data);
                chk("stall_last", rd_last, prev_last);
                chk("stall_final", rd_final, prev_fin);
            end
        end
        prev_stall = rd_valid && !rd_ready && !rst;
        prev_data  = rd_data;
        prev_last  = rd_last;
        prev_fin   = rd_final;
        if (rd_valid && rd_ready && !rst) begin
            if (acc_words == 0) acc_first = rd_data;
            acc_words++;
            if (rd_last) acc_last++;
            if (rd_final) acc_final++;
        end
    end

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; flush = 1'b0;
        to_next();
        rst = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        @(negedge clk);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_rd_data"}, rd_data, '0);
        chk({tag, "_rd_last"}, rd_last, 1'b0);
        chk({tag, "_rd_final"}, rd_final, 1'b0);
        chk({tag, "_bank_full"}, bank_full, 2'b00);
        chk({tag, "_wr_bank"}, wr_bank, 1'b0);
        chk({tag, "_rd_bank"}, rd_bank, 1'b0);
        chk({tag, "_wr_ready"}, wr_ready, 1'b1);
        to_next();
    endtask

    task automatic write_word(input logic [N-1:0] d);
        wr_valid = 1'b1; wr_data = d;
        to_next();
        wr_valid = 1'b0;
    endtask

    task automatic clr_acc();
        acc_words = 0; acc_last = 0; acc_final = 0; acc_first = '0;
    endtask

    typedef struct {
        bit           wv;
        logic [N-1:0] wd;
        bit           rr;
        bit           rv;
        logic [N-1:0] rd;
        bit           rl;
        bit           rf;
        bit           wrdy;
        logic [1:0]   bf;
    } vec_t;

    vec_t vt[10];
    bit   found;

    initial begin
        // Single bank, one pass: values are those visible during each cycle.
        vt[0] = '{1, 16'h0011, 1, 0, 16'h0000, 0, 0, 1, 2'b00};
        vt[1] = '{1, 16'h0022, 1, 0, 16'h0000, 0, 0, 1, 2'b00};
        vt[2] = '{1, 16'h0033, 1, 0, 16'h0000, 0, 0, 1, 2'b00};
        vt[3] = '{1, 16'h0044, 1, 0, 16'h0000, 0, 0, 1, 2'b00};
        vt[4] = '{0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1, 2'b01};
        vt[5] = '{0, 16'h0000, 1, 1, 16'h0011, 0, 0, 1, 2'b01};
        vt[6] = '{0, 16'h0000, 1, 1, 16'h0022, 0, 0, 1, 2'b01};
        vt[7] = '{0, 16'h0000, 1, 1, 16'h0033, 0, 0, 1, 2'b01};
        vt[8] = '{0, 16'h0000, 1, 1, 16'h0044, 1, 1, 1, 2'b00};
        vt[9] = '{0, 16'h0000, 1, 0, 16'h0044, 0, 0, 1, 2'b00};

        rst = 1'b1; wr_valid = 1'b0; wr_data = '0; flush = 1'b0;
        pass_count = 4'd1; rd_ready = 1'b0;
        to_next();
        to_next();
        rst = 1'b0;
        chk_en = 1;
        reset_checks("por");

        for (int i = 0; i < 10; i++) begin
            wr_valid = vt[i].wv; wr_data = vt[i].wd; rd_ready = vt[i].rr;
            @(negedge clk);
            chk($sformatf("tbl%0d_rd_valid", i), rd_valid, vt[i].rv);
            chk($sformatf("tbl%0d_rd_data", i), rd_data, vt[i].rd);
            if (vt[i].rv) begin
                chk($sformatf("tbl%0d_rd_last", i), rd_last, vt[i].rl);
                chk($sformatf("tbl%0d_rd_final", i), rd_final, vt[i].rf);
            end
            chk($sformatf("tbl%0d_wr_ready", i), wr_ready, vt[i].wrdy);
            chk($sformatf("tbl%0d_bank_full", i), bank_full, vt[i].bf);
            to_next();
        end
        wr_valid = 1'b0;

        // Ping-pong: both banks filled while the reader is stalled.
        do_reset();
        rd_ready = 1'b0; pass_count = 4'd1;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_data = 16'h0100 + 16'(i);
            @(negedge clk);
            chk($sformatf("pp_wr_ready%0d", i), wr_ready, 1'b1);
            to_next();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("pp_both_full_wr_ready", wr_ready, 1'b0);
        chk("pp_both_full_bank_full", bank_full, 2'b11);
        chk("pp_word0_data", rd_data, 16'h0100);
        to_next();
        rd_ready = 1'b1;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (rd_valid && rd_final) begin
                found = 1;
                chk("pp_release_data", rd_data, 16'h0103);
                chk("pp_release_wr_ready", wr_ready, 1'b1);
                chk("pp_release_bank_full", bank_full, 2'b10);
            end
            to_next();
        end
        chk("pp_release_seen", found, 1'b1);
        repeat (8) to_next();

        // Replay: pass_count 3 on one bank, 0 on the next.
        clr_acc();
        rd_ready = 1'b1; pass_count = 4'd3;
        for (int i = 0; i < 4; i++) write_word(16'h0200 + 16'(i));
        pass_count = 4'd0;
        for (int i = 0; i < 4; i++) write_word(16'h0300 + 16'(i));
        repeat (24) to_next();
        chk("rpt_words", acc_words, 16);
        chk("rpt_last_count", acc_last, 4);
        chk("rpt_final_count", acc_final, 2);

        // Backpressure: consumer ready every other cycle.
        clr_acc();
        pass_count = 4'd2;
        for (int i = 0; i < 4; i++) begin
            rd_ready = i[0];
            write_word(16'h0400 + 16'(i));
        end
        for (int k = 0; k < 30; k++) begin
            rd_ready = k[0];
            to_next();
        end
        rd_ready = 1'b1;
        to_next();
        chk("bp_words", acc_words, 8);
        chk("bp_final_count", acc_final, 1);
        chk("bp_first", acc_first, 16'h0400);

        // Flush after two writes, then refill the same bank.
        do_reset();
        rd_ready = 1'b1; pass_count = 4'd1;
        write_word(16'h00a0);
        write_word(16'h00a1);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_wr_ready_low", wr_ready, 1'b0);
        to_next();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_bank_full", bank_full, 2'b00);
        chk("fl_wr_bank", wr_bank, 1'b0);
        to_next();
        clr_acc();
        for (int i = 0; i < 4; i++) write_word(16'h00b0 + 16'(i));
        repeat (8) to_next();
        chk("fl_refill_words", acc_words, 4);
        chk("fl_refill_first", acc_first, 16'h00b0);

        // Flush coincident with the final word of a bank.
        for (int i = 0; i < 3; i++) write_word(16'h00c0 + 16'(i));
        wr_valid = 1'b1; wr_data = 16'h00c3; flush = 1'b1;
        @(negedge clk);
        chk("flc_wr_ready", wr_ready, 1'b0);
        to_next();
        wr_valid = 1'b0; flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flc_bank_full", bank_full, 2'b00);
            chk("flc_rd_valid", rd_valid, 1'b0);
            to_next();
        end
        clr_acc();
        for (int i = 0; i < 4; i++) write_word(16'h00d0 + 16'(i));
        repeat (8) to_next();
        chk("flc_refill_words", acc_words, 4);
        chk("flc_refill_first", acc_first, 16'h00d0);

        // Synchronous reset in the middle of a drain.
        pass_count = 4'd2;
        for (int i = 0; i < 4; i++) write_word(16'h00e0 + 16'(i));
        repeat (3) to_next();
        do_reset();
        reset_checks("mid");

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            wr_valid   = ($urandom_range(0, 3) != 0);
            wr_data    = N'($urandom);
            rd_ready   = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 24) == 0);
            pass_count = RPT_W'($urandom_range(0, 3));
            to_next();
        end
        wr_valid = 1'b0; flush = 1'b0; rd_ready = 1'b1;
        repeat (40) to_next();
        @(negedge clk);
        chk("end_bank_full", bank_full, 2'b00);
        chk("end_rd_valid", rd_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
